conv_frame_streamer: RTL

Drains one flattened conv output frame (30x30 signed 13-bit pixels, packed as a single wide bus) into a pixel-per-beat stream with valid/ready handshake. Sits at the conv output and feeds downstream logic such as a pooling stage, DMA or bench file sink, replacing wide-bus sampling. Emits raster order, which is the index order used to pack the frame. Each beat carries frame, line and position markers.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_raster_cnt.sv | 32 +++
 rtl/conv_frame_streamer.sv | 61 ++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared frame geometry, pixel type and FSM states for the conv datapath
package conv_pkg;
    localparam int PIX_W = 13;
    localparam int IN_W  = 32;
    localparam int IN_H  = 32;
    localparam int OUT_W = 30;
    localparam int OUT_H = 30;
    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef enum logic {IDLE, STREAM} state_t;
    function automatic int pix_index(input int row, input int col);
        return row * OUT_W + col;
    endfunction
endpackage

// File: rtl/conv_raster_cnt.sv
// conv_raster_cnt: raster row/col counter with enable, wrap and sof/eol/eof decode
// ports: clk, rst_n | en advances one position | row, col current position | sof/eol/eof position markers
module conv_raster_cnt #(
    parameter int W = 30,
    parameter int H = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(W)-1:0] col,
    output logic                 sof,
    output logic                 eol,
    output logic                 eof
);
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    assign sof = (row == '0) && (col == '0);
    assign eol = col == COL_MAX;
    assign eof = eol && (row == ROW_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            col <= eol ? '0 : col + 1'b1;
            row <= eof ? '0 : eol ? row + 1'b1 : row;
        end
    end
endmodule

// File: rtl/conv_frame_streamer.sv
// conv_frame_streamer: captures a packed conv frame and streams it pixel-per-beat in raster order
// ports: clk, rst_n | start captures frame_in | busy, done status | m_valid/m_ready handshake
//        m_data pixel, m_row/m_col position, m_sof/m_eol/m_eof markers
module conv_frame_streamer import conv_pkg::*; #(
    parameter int PIX_W = conv_pkg::PIX_W,
    parameter int IMG_W = conv_pkg::OUT_W,
    parameter int IMG_H = conv_pkg::OUT_H
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PIX_W*IMG_W*IMG_H-1:0] frame_in,
    output logic                         busy,
    output logic                         done,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [PIX_W-1:0]             m_data,
    output logic [$clog2(IMG_H)-1:0]     m_row,
    output logic [$clog2(IMG_W)-1:0]     m_col,
    output logic                         m_sof,
    output logic                         m_eol,
    output logic                         m_eof
);
    state_t state_q, state_d;
    logic [PIX_W*IMG_W*IMG_H-1:0] shadow;
    logic fire, sof, eol, eof;
    assign m_valid = state_q == STREAM;
    assign busy    = m_valid;
    assign fire    = m_valid && m_ready;
    // shadow shifts one pixel out per transfer, so it is all zero again once a frame completes
    assign m_data  = shadow[PIX_W-1:0];
    assign m_sof   = m_valid && sof;
    assign m_eol   = m_valid && eol;
    assign m_eof   = m_valid && eof;
    conv_raster_cnt #(.W(IMG_W), .H(IMG_H)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (fire),
        .row  (m_row),
        .col  (m_col),
        .sof  (sof),
        .eol  (eol),
        .eof  (eof)
    );
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start) state_d = STREAM;
        if (fire && eof) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shadow  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= fire && eof;
            shadow  <= (state_q == IDLE && start) ? frame_in : fire ? shadow >> PIX_W : shadow;
        end
    end
endmodule
